// File: rtl/multdiv_unit_if.sv
// Execute <-> multdiv_unit handshake bundle: start pulses, operands, result and status.
interface multdiv_unit_if #(parameter int XLEN = 32);
  logic            ctrl_MULT;
  logic            ctrl_DIV;
  logic [XLEN-1:0] data_operandA;
  logic [XLEN-1:0] data_operandB;
  logic [XLEN-1:0] data_result;
  logic            data_exception;
  logic            data_resultRDY;
  logic            busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed XLEN-bit multiply/divide unit.
// Multiply: radix-2 shift-add over a 2*XLEN product, XLEN edges.
// Divide: restoring division on magnitudes, XLEN edges; divide-by-zero finishes in one.
// Build option MULTDIV_DIV_EN: when undefined the divider is left out and every
// divide request answers like a divide-by-zero (result 0, exception 1).
// A start sampled in any state (including mid-operation) restarts the unit.
module multdiv_unit #(
  parameter int XLEN = 32
) (
  input logic           clock,
  input logic           reset,
  multdiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
`ifdef MULTDIV_DIV_EN
    S_DIV,
`endif
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] mcand_q, prod_q, prod_d, addend;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   result_q;
  logic              exc_q, rdy_q, busy_q, dz_q;
  logic              last;
  logic [XLEN:0]     hi_bits;
  logic              mul_ovf;

  // Multiply step: add the shifted multiplicand for each set multiplier bit;
  // the top bit carries negative weight, so the last step subtracts.
  always_comb begin
    last    = (cnt_q == LAST);
    addend  = '0;
    if (mplier_q[0]) addend = last ? -mcand_q : mcand_q;
    prod_d  = prod_q + addend;
    hi_bits = prod_d[2*XLEN-1:XLEN-1];
    mul_ovf = (|hi_bits) & ~(&hi_bits);
  end

`ifdef MULTDIV_DIV_EN
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, rem_d, quo_d, qres;
  logic [XLEN:0]   r_sh, diff;
  logic            neg_q, ge, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  // Divide step: shift in the next dividend bit and subtract when it fits.
  // Remainder stays below the divisor, so the trial difference's sign bit
  // is the inverse of the quotient bit.
  always_comb begin
    abs_a   = bus.data_operandA[XLEN-1] ? -bus.data_operandA : bus.data_operandA;
    abs_b   = bus.data_operandB[XLEN-1] ? -bus.data_operandB : bus.data_operandB;
    r_sh    = {rem_q, quo_q[XLEN-1]};
    diff    = r_sh - {1'b0, dvsr_q};
    ge      = ~diff[XLEN];
    rem_d   = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], ge};
    qres    = neg_q ? -quo_d : quo_d;
    // A positive quotient with the top bit set only comes from MIN / -1.
    div_ovf = ~neg_q & quo_d[XLEN-1];
  end
`endif

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      dz_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b0;
      if (bus.ctrl_MULT) begin
        state_q  <= S_MUL;
        cnt_q    <= '0;
        mcand_q  <= {{XLEN{bus.data_operandA[XLEN-1]}}, bus.data_operandA};
        mplier_q <= bus.data_operandB;
        prod_q   <= '0;
        dz_q     <= 1'b0;
        busy_q   <= 1'b1;
      end else if (bus.ctrl_DIV) begin
        cnt_q  <= '0;
        busy_q <= 1'b1;
`ifdef MULTDIV_DIV_EN
        state_q <= S_DIV;
        dvsr_q  <= abs_b;
        quo_q   <= abs_a;
        rem_q   <= '0;
        neg_q   <= bus.data_operandA[XLEN-1] ^ bus.data_operandB[XLEN-1];
        dz_q    <= (bus.data_operandB == '0);
`else
        // No divider: park in MUL with the zero flag so DONE follows next edge.
        state_q <= S_MUL;
        dz_q    <= 1'b1;
`endif
      end else begin
        case (state_q)
          S_MUL: begin
            if (dz_q) begin
              state_q  <= S_DONE;
              result_q <= '0;
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
            end else begin
              prod_q   <= prod_d;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
              cnt_q    <= cnt_q + CW'(1);
              if (last) begin
                state_q  <= S_DONE;
                result_q <= prod_d[XLEN-1:0];
                exc_q    <= mul_ovf;
                rdy_q    <= 1'b1;
              end
            end
          end
`ifdef MULTDIV_DIV_EN
          S_DIV: begin
            if (dz_q) begin
              state_q  <= S_DONE;
              result_q <= '0;
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
            end else begin
              rem_q <= rem_d;
              quo_q <= quo_d;
              cnt_q <= cnt_q + CW'(1);
              if (last) begin
                state_q  <= S_DONE;
                result_q <= qres;
                exc_q    <= div_ovf;
                rdy_q    <= 1'b1;
              end
            end
          end
`endif
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule
